// File: rtl/sq_df_ctrl.sv
// sq_df_ctrl: streams one pixel/signature band pair per handshake into an
// external squared-difference pipeline, tags each accepted pair so its
// product can be recognised when it leaves the pipeline, and accumulates the
// tagged products into a squared Euclidean distance presented on a
// valid/ready result port.
module sq_df_ctrl #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned HSP_BANDS     = 16,
    parameter int unsigned SQ_DF_LATENCY = 2,
    localparam int unsigned ACC_WIDTH    = 2 * DATA_WIDTH + $clog2(HSP_BANDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    band_valid,
    output logic                    band_ready,
    input  logic [DATA_WIDTH-1:0]   band_v1,
    input  logic [DATA_WIDTH-1:0]   band_v2,
    output logic [DATA_WIDTH-1:0]   sq_v1,
    output logic [DATA_WIDTH-1:0]   sq_v2,
    input  logic [2*DATA_WIDTH-1:0] sq_result,
    output logic                    dist_valid,
    input  logic                    dist_ready,
    output logic [ACC_WIDTH-1:0]    dist_out,
    output logic                    busy
);

    // Wide enough to hold the value HSP_BANDS itself.
    localparam int unsigned CNT_WIDTH = $clog2(HSP_BANDS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     band_cnt_q, band_cnt_d;
    logic [CNT_WIDTH-1:0]     band_cnt_inc;
    logic [SQ_DF_LATENCY-1:0] tag_q, tag_d;
    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [ACC_WIDTH-1:0]     acc_sum;
    logic [ACC_WIDTH-1:0]     dist_out_q, dist_out_d;
    logic                     dist_valid_q, dist_valid_d;

    logic handshake;
    logic tag_out;
    logic tags_pending;

    // Band acceptance decodes from state; clear blocks acceptance so an offered
    // band in the abort cycle is visibly refused rather than silently dropped.
    always_comb begin
        band_ready = ((state_q == StIdle) || (state_q == StStream)) && !clear;
        handshake  = band_valid && band_ready;
        sq_v1      = handshake ? band_v1 : '0;
        sq_v2      = handshake ? band_v2 : '0;
        busy       = (state_q != StIdle);
        dist_valid = dist_valid_q;
        dist_out   = dist_out_q;
    end

    // Tag pipe shifts every cycle; stage 0 marks a product entering sq_df.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = handshake;
        for (int i = 1; i < int'(SQ_DF_LATENCY); i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (clear) begin
            tag_d = '0;
        end
    end

    // Output-stage tag qualifies sq_result; any earlier tag means work in flight.
    always_comb begin
        tag_out      = tag_q[SQ_DF_LATENCY-1];
        tags_pending = 1'b0;
        for (int i = 0; i < int'(SQ_DF_LATENCY) - 1; i++) begin
            tags_pending = tags_pending | tag_q[i];
        end
        acc_sum = acc_q + (tag_out ? ACC_WIDTH'(sq_result) : '0);
    end

    assign band_cnt_inc = band_cnt_q + CNT_WIDTH'(1);

    // Next-state and datapath control for the band sequencer.
    always_comb begin
        state_d      = state_q;
        band_cnt_d   = band_cnt_q;
        acc_d        = acc_sum;
        dist_out_d   = dist_out_q;
        dist_valid_d = dist_valid_q;

        unique case (state_q)
            StIdle: begin
                acc_d = '0;
                if (handshake) begin
                    band_cnt_d = CNT_WIDTH'(1);
                    state_d    = (HSP_BANDS == 1) ? StDrain : StStream;
                end
            end
            StStream: begin
                if (handshake) begin
                    band_cnt_d = band_cnt_inc;
                    if (band_cnt_inc == CNT_WIDTH'(HSP_BANDS)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The last product is either already in acc or at the output
                // stage now; acc_sum folds it in so the result is not delayed.
                if (!tags_pending) begin
                    dist_out_d   = acc_sum;
                    dist_valid_d = 1'b1;
                    state_d      = StDone;
                end
            end
            StDone: begin
                if (dist_ready) begin
                    dist_valid_d = 1'b0;
                    acc_d        = '0;
                    band_cnt_d   = '0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over any handshake or completion in the same cycle.
        if (clear) begin
            state_d      = StIdle;
            band_cnt_d   = '0;
            acc_d        = '0;
            dist_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            band_cnt_q   <= '0;
            tag_q        <= '0;
            acc_q        <= '0;
            dist_out_q   <= '0;
            dist_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            band_cnt_q   <= band_cnt_d;
            tag_q        <= tag_d;
            acc_q        <= acc_d;
            dist_out_q   <= dist_out_d;
            dist_valid_q <= dist_valid_d;
        end
    end

endmodule

// File: tb/tb_sq_df_ctrl.sv
// Directed bench for sq_df_ctrl with a behavioural two-stage sq_df and a
// scoreboard queue of expected distances.
module tb_sq_df_ctrl;

    localparam int unsigned DW  = 16;
    localparam int unsigned NB  = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned AW  = 2 * DW + $clog2(NB);

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          band_valid;
    logic          band_ready;
    logic [DW-1:0] band_v1, band_v2;
    logic [DW-1:0] sq_v1, sq_v2;
    logic [2*DW-1:0] sq_result;
    logic          dist_valid;
    logic          dist_ready;
    logic [AW-1:0] dist_out;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = 0;
    longint unsigned sb[$];

    sq_df_ctrl #(
        .DATA_WIDTH   (DW),
        .HSP_BANDS    (NB),
        .SQ_DF_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .band_valid(band_valid),
        .band_ready(band_ready),
        .band_v1   (band_v1),
        .band_v2   (band_v2),
        .sq_v1     (sq_v1),
        .sq_v2     (sq_v2),
        .sq_result (sq_result),
        .dist_valid(dist_valid),
        .dist_ready(dist_ready),
        .dist_out  (dist_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Behavioural sq_df: (v1-v2)^2 with two register stages.
    logic [DW-1:0]   m_diff;
    logic [2*DW-1:0] m_s1, m_s2;
    assign m_diff = (sq_v1 >= sq_v2) ? (sq_v1 - sq_v2) : (sq_v2 - sq_v1);
    always_ff @(posedge clk) begin
        m_s1 <= (2*DW)'(m_diff) * (2*DW)'(m_diff);
        m_s2 <= m_s1;
    end
    assign sq_result = m_s2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned exp_dist(input logic [DW-1:0] a[NB],
                                                 input logic [DW-1:0] b[NB]);
        longint unsigned s = 0;
        longint unsigned d;
        for (int i = 0; i < int'(NB); i++) begin
            d = (a[i] >= b[i]) ? longint'(a[i] - b[i]) : longint'(b[i] - a[i]);
            s += d * d;
        end
        return s;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        band_valid = 1'b0;
        band_v1 = DW'($urandom);
        band_v2 = DW'($urandom);
        #1;
        chk("sq_v1_idle_zero", 64'(sq_v1), 64'd0);
        chk("sq_v2_idle_zero", 64'(sq_v2), 64'd0);
    endtask

    task automatic drive_band(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int n = 0;
        @(negedge clk);
        band_valid = 1'b1;
        band_v1 = x;
        band_v2 = y;
        #1;
        while (!band_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("band_ready_accept", 64'(band_ready), 64'd1);
        chk("sq_v1_pass", 64'(sq_v1), 64'(x));
        chk("sq_v2_pass", 64'(sq_v2), 64'(y));
        last_hs = cyc;
    endtask

    task automatic send_vec(input logic [DW-1:0] a[NB], input logic [DW-1:0] b[NB],
                            input int max_gap);
        for (int i = 0; i < int'(NB); i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) idle_cycle();
            drive_band(a[i], b[i]);
        end
        @(negedge clk);
        band_valid = 1'b0;
        sb.push_back(exp_dist(a, b));
    endtask

    task automatic collect(input int hold);
        int n = 0;
        longint unsigned exp;
        @(negedge clk);
        #1;
        while (!dist_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("dist_valid_rise", 64'(dist_valid), 64'd1);
        chk("result_latency", 64'(cyc - last_hs), 64'(LAT + 1));
        exp = sb.pop_front();
        chk("dist_out", 64'(dist_out), exp);
        chk("band_ready_done", 64'(band_ready), 64'd0);
        repeat (hold) begin
            @(negedge clk);
            #1;
            chk("hold_dist_valid", 64'(dist_valid), 64'd1);
            chk("hold_dist_out", 64'(dist_out), exp);
            chk("hold_band_ready", 64'(band_ready), 64'd0);
        end
        dist_ready = 1'b1;
        @(negedge clk);
        dist_ready = 1'b0;
        #1;
        chk("dist_valid_fall", 64'(dist_valid), 64'd0);
        chk("dist_out_kept", 64'(dist_out), exp);
        chk("band_ready_idle", 64'(band_ready), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    logic [DW-1:0] va[NB], vb[NB];

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        band_valid = 1'b0;
        band_v1 = '0;
        band_v2 = '0;
        dist_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_dist_valid", 64'(dist_valid), 64'd0);
        chk("rst_dist_out", 64'(dist_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_band_ready", 64'(band_ready), 64'd1);

        // Basic vector, back-to-back bands.
        va = '{16'd5, 16'd3, 16'd10, 16'd0};
        vb = '{16'd3, 16'd5, 16'd7, 16'd0};
        send_vec(va, vb, 0);
        collect(0);

        // Full-scale products must not truncate.
        va = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vb = '{16'h0, 16'h0, 16'h0, 16'h0};
        send_vec(va, vb, 0);
        collect(0);
        chk("full_scale_const", 64'(dist_out), 64'h3_FFF8_0004);

        // Bubbles on the input plus five cycles of result backpressure.
        va = '{16'd5, 16'd3, 16'd10, 16'd0};
        vb = '{16'd3, 16'd5, 16'd7, 16'd0};
        send_vec(va, vb, 3);
        collect(5);

        // Next vector must start from a cleared accumulator.
        va = '{16'd1, 16'd1, 16'd1, 16'd1};
        vb = '{16'd0, 16'd0, 16'd0, 16'd0};
        send_vec(va, vb, 0);
        collect(0);

        // Abort after two bands; the band offered with clear is refused.
        drive_band(16'd5, 16'd3);
        drive_band(16'd3, 16'd5);
        @(negedge clk);
        band_valid = 1'b1;
        band_v1 = 16'd10;
        band_v2 = 16'd7;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        band_valid = 1'b0;
        #1;
        chk("clear_busy", 64'(busy), 64'd0);
        chk("clear_band_ready", 64'(band_ready), 64'd1);
        chk("clear_dist_valid", 64'(dist_valid), 64'd0);
        va = '{16'd5, 16'd3, 16'd10, 16'd0};
        vb = '{16'd3, 16'd5, 16'd7, 16'd0};
        send_vec(va, vb, 0);
        collect(0);

        // Asynchronous reset with products in flight.
        drive_band(16'd200, 16'd0);
        drive_band(16'd300, 16'd0);
        @(negedge clk);
        band_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dist_valid", 64'(dist_valid), 64'd0);
        chk("arst_dist_out", 64'(dist_out), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_band_ready", 64'(band_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        send_vec(va, vb, 1);
        collect(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
